lif_membrane_update: RTL



---
 rtl/lif_membrane_update.sv | 57 +++++
 1 files changed

// File: rtl/lif_membrane_update.sv
// lif_membrane_update: saturating membrane-potential register with fire/refractory control for a LIF neuron.
module lif_membrane_update #(
  parameter logic signed [15:0] V_RESET = 16'sd0,
  parameter int REFRAC_STEPS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        diff_valid,
  output logic        diff_ready,
  input  logic [16:0] diff,
  input  logic [14:0] threshold,
  output logic [15:0] v_mem,
  output logic        spike,
  output logic        refractory,
  output logic        out_valid,
  output logic [7:0]  spike_count
);
  typedef enum logic [1:0] {INTEGRATE, FIRE, REFRAC} state_t;
  localparam logic [3:0] STEPS = 4'(REFRAC_STEPS);
  state_t state, state_nxt;
  logic [3:0] refrac_cnt, refrac_cnt_nxt;
  logic signed [15:0] sat, v_mem_nxt;
  logic xfer, fire, enter_fire;
  assign diff_ready = state != FIRE;
  assign xfer = diff_valid && diff_ready;
  // Clamp by inspecting the two top bits of the 17-bit difference.
  assign sat = (!diff[16] && diff[15]) ? 16'h7fff : (diff[16] && !diff[15]) ? 16'h8000 : diff[15:0];
  assign fire = sat >= $signed({1'b0, threshold});
  assign enter_fire = state == INTEGRATE && xfer && fire;
  assign spike = state == FIRE;
  assign refractory = state == REFRAC;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INTEGRATE;
      refrac_cnt <= 4'd0;
      v_mem <= V_RESET;
      out_valid <= 1'b0;
      spike_count <= 8'd0;
    end else begin
      state <= state_nxt;
      refrac_cnt <= refrac_cnt_nxt;
      v_mem <= v_mem_nxt;
      out_valid <= xfer;
      spike_count <= (enter_fire && spike_count != 8'hff) ? spike_count + 8'd1 : spike_count;
    end
  end
  always_comb begin
    state_nxt = state == INTEGRATE ? (enter_fire ? FIRE : INTEGRATE)
              : state == FIRE ? (STEPS != 4'd0 ? REFRAC : INTEGRATE)
              : ((xfer && refrac_cnt == 4'd1) ? INTEGRATE : REFRAC);
  end
  always_comb begin
    v_mem_nxt = (state == INTEGRATE && xfer) ? (fire ? V_RESET : sat)
              : state == REFRAC ? V_RESET : v_mem;
    refrac_cnt_nxt = enter_fire ? STEPS : (state == REFRAC && xfer) ? refrac_cnt - 4'd1 : refrac_cnt;
  end
endmodule
